adrv9001_mssi_sync_sequencer: RTL and testbench



---
 rtl/adrv9001_mssi_sync_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_adrv9001_mssi_sync_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_mssi_sync_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adrv9001_mssi_sync_sequencer
// Brief    : Quiesces the ADRV9001 channel enables, drives a timed mssi_sync
//            pulse, waits for the SSI clocks to settle, then restores enables.
//            Define ADRV9001_MSSI_EXT_SYNC_EN to add the ext_sync trigger input.
// Revision : 1.0 - initial release
// ============================================================================
module adrv9001_mssi_sync_sequencer #(
    parameter int QUIESCE_CYCLES = 16,
    parameter int PULSE_CYCLES   = 100,
    parameter int SETTLE_CYCLES  = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sync_req,
`ifdef ADRV9001_MSSI_EXT_SYNC_EN
    input  logic       ext_sync,
`endif
    input  logic [3:0] chan_enable_req,
    output logic [3:0] chan_enable,
    output logic       mssi_sync,
    output logic       busy,
    output logic       done,
    output logic [7:0] sync_count
);

    localparam longint c_cnt_max = (longint'(1) << CNT_WIDTH) - 1;

    localparam logic [CNT_WIDTH-1:0] c_quiesce_last = CNT_WIDTH'(QUIESCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_pulse_last   = CNT_WIDTH'(PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_settle_last  =
        (SETTLE_CYCLES == 0) ? '0 : CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam bit                   c_settle_zero  = (SETTLE_CYCLES == 0);

    generate
        if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt_width
            $error("CNT_WIDTH must be in 1..32");
        end
        if (QUIESCE_CYCLES < 1 || longint'(QUIESCE_CYCLES) > c_cnt_max) begin : g_bad_quiesce
            $error("QUIESCE_CYCLES must be in 1..2^CNT_WIDTH-1");
        end
        if (PULSE_CYCLES < 1 || longint'(PULSE_CYCLES) > c_cnt_max) begin : g_bad_pulse
            $error("PULSE_CYCLES must be in 1..2^CNT_WIDTH-1");
        end
        if (SETTLE_CYCLES < 0 || longint'(SETTLE_CYCLES) > c_cnt_max) begin : g_bad_settle
            $error("SETTLE_CYCLES must be in 0..2^CNT_WIDTH-1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUIESCE = 3'd1,
        S_PULSE   = 3'd2,
        S_SETTLE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_pending;
    logic [3:0]           r_chan;
    logic                 r_mssi;
    logic                 r_busy;
    logic                 r_done;
    logic [7:0]           r_count;
    logic                 w_trigger;

`ifdef ADRV9001_MSSI_EXT_SYNC_EN
    logic r_ext_meta;
    logic r_ext_sync;
    logic r_ext_prev;
    logic r_ext_trig;

    // Two-flop synchronizer, then a registered rising-edge detect (3-cycle latency).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ext_meta <= 1'b0;
            r_ext_sync <= 1'b0;
            r_ext_prev <= 1'b0;
            r_ext_trig <= 1'b0;
        end else begin
            r_ext_meta <= ext_sync;
            r_ext_sync <= r_ext_meta;
            r_ext_prev <= r_ext_sync;
            r_ext_trig <= r_ext_sync & ~r_ext_prev;
        end
    end

    assign w_trigger = sync_req | r_ext_trig;
`else
    assign w_trigger = sync_req;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_chan    <= 4'b0;
            r_mssi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_done <= 1'b0;
            // Only one request can be queued while a sequence is running.
            if (r_state != S_IDLE && w_trigger) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_trigger || r_pending) begin
                        r_state   <= S_QUIESCE;
                        r_busy    <= 1'b1;
                        r_pending <= 1'b0;
                        r_cnt     <= '0;
                        r_chan    <= 4'b0;
                    end else begin
                        r_chan <= chan_enable_req;
                    end
                end

                S_QUIESCE: begin
                    if (r_cnt == c_quiesce_last) begin
                        r_state <= S_PULSE;
                        r_cnt   <= '0;
                        r_mssi  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_PULSE: begin
                    if (r_cnt == c_pulse_last) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                        r_mssi  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_SETTLE: begin
                    // A zero settle time still spends one cycle here.
                    if (c_settle_zero || r_cnt == c_settle_last) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_chan  <= chan_enable_req;
                        r_count <= r_count + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_chan  <= chan_enable_req;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_mssi  <= 1'b0;
                    r_chan  <= 4'b0;
                end
            endcase
        end
    end

    assign chan_enable = r_chan;
    assign mssi_sync   = r_mssi;
    assign busy        = r_busy;
    assign done        = r_done;
    assign sync_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_adrv9001_mssi_sync_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adrv9001_mssi_sync_sequencer
// Brief    : Directed and randomized stimulus with an event scoreboard for the
//            MSSI sync sequencer (ext_sync phase under ADRV9001_MSSI_EXT_SYNC_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adrv9001_mssi_sync_sequencer;

    localparam int Q      = 16;
    localparam int P      = 100;
    localparam int S      = 64;
    localparam int D      = Q + P + S + 1;
    localparam int NCYC   = 16384;
    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_DONE = 2;

    logic       clk             = 1'b0;
    logic       resetn          = 1'b0;
    logic       sync_req        = 1'b0;
    logic [3:0] chan_enable_req = 4'h0;
    logic [3:0] chan_enable;
    logic       mssi_sync;
    logic       busy;
    logic       done;
    logic [7:0] sync_count;
`ifdef ADRV9001_MSSI_EXT_SYNC_EN
    logic       ext_sync        = 1'b0;
`endif

    always #5 clk = ~clk;

    adrv9001_mssi_sync_sequencer #(
        .QUIESCE_CYCLES (Q),
        .PULSE_CYCLES   (P),
        .SETTLE_CYCLES  (S),
        .CNT_WIDTH      (16)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .sync_req        (sync_req),
`ifdef ADRV9001_MSSI_EXT_SYNC_EN
        .ext_sync        (ext_sync),
`endif
        .chan_enable_req (chan_enable_req),
        .chan_enable     (chan_enable),
        .mssi_sync       (mssi_sync),
        .busy            (busy),
        .done            (done),
        .sync_count      (sync_count)
    );

    typedef struct {
        int kind;
        int cyc;
        int count;
    } ev_t;

    ev_t        evq[$];
    bit         rst_h  [NCYC];
    bit         idle_h [NCYC];
    bit         done_h [NCYC];
    bit         trig_h [NCYC];
    logic [3:0] req_h  [NCYC];

    int         cyc         = 0;
    int         busy_until  = -1;
    bit         pending     = 1'b0;
    int         model_count = 0;
    bit         mon_on      = 1'b0;
    int         n_pass      = 0;
    int         n_total     = 0;
    logic       p_mssi      = 1'b0;
    int         a;
    logic [3:0] rnd_ena;
    bit         rnd_req;
    bit         rnd_rstn;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endfunction

    // Reference model: a sequence accepted in idle cycle t occupies cycles
    // t+1 .. t+D, with mssi_sync over [t+1+Q, t+Q+P] and done at t+D.
    task automatic step(input bit req, input logic [3:0] ena, input bit rstn);
        bit  trig;
        ev_t keep[$];
        sync_req        = req;
        chan_enable_req = ena;
        resetn          = rstn;
        trig            = req | trig_h[cyc];
        rst_h[cyc]      = !rstn;
        req_h[cyc]      = ena;
        idle_h[cyc]     = (cyc > busy_until);
        if (!rstn) begin
            busy_until  = cyc;
            pending     = 1'b0;
            model_count = 0;
            foreach (evq[i]) if (evq[i].cyc <= cyc) keep.push_back(evq[i]);
            evq = keep;
            for (int i = cyc + 1; i < NCYC && i <= cyc + D + 1; i++) done_h[i] = 1'b0;
        end else if (idle_h[cyc]) begin
            if (trig || pending) begin
                pending     = 1'b0;
                busy_until  = cyc + D;
                model_count = (model_count + 1) % 256;
                evq.push_back('{K_RISE, cyc + 1 + Q, 0});
                evq.push_back('{K_FALL, cyc + 1 + Q + P, 0});
                evq.push_back('{K_DONE, cyc + D, model_count});
                if (cyc + D < NCYC) done_h[cyc + D] = 1'b1;
            end
        end else if (trig) begin
            pending = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pop_ev(input int kind);
        ev_t e;
        if (evq.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event at cycle %0d: got event kind %0d, expected none", cyc, kind);
        end else begin
            e = evq.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            if (kind == K_DONE) begin
                chk("done_chan_enable", 32'(chan_enable), 32'(req_h[cyc - 1]));
                chk("done_sync_count", 32'(sync_count), 32'(e.count));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && cyc >= 1) begin
            if (rst_h[cyc - 1]) begin
                chk("reset_state", 32'({chan_enable, mssi_sync, busy, done, sync_count}), 32'd0);
            end else begin
                chk("busy", 32'(busy), 32'(!idle_h[cyc]));
                if (idle_h[cyc])
                    chk("chan_enable_idle", 32'(chan_enable), 32'(req_h[cyc - 1]));
                else if (!done_h[cyc])
                    chk("chan_enable_quiet", 32'(chan_enable), 32'd0);
                if (mssi_sync && !p_mssi) pop_ev(K_RISE);
                if (!mssi_sync && p_mssi) pop_ev(K_FALL);
                if (done) pop_ev(K_DONE);
            end
            p_mssi = mssi_sync;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        cyc    = 0;
        mon_on = 1'b1;

        // Reset, then enables follow the request while idle
        repeat (3) step(1'b0, 4'hF, 1'b0);
        repeat (5) step(1'b0, 4'hF, 1'b1);

        // Single one-cycle request
        step(1'b1, 4'hF, 1'b1);
        repeat (D + 5) step(1'b0, 4'hF, 1'b1);

        // Two requests during PULSE queue exactly one more sequence
        a = cyc;
        step(1'b1, 4'hF, 1'b1);
        while (cyc < a + 1 + Q + 10) step(1'b0, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        repeat (5) step(1'b0, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        repeat (2 * D + 10) step(1'b0, 4'hF, 1'b1);

        // Enable request changes during SETTLE are taken only at DONE
        a = cyc;
        step(1'b1, 4'hF, 1'b1);
        while (cyc < a + 1 + Q + P + 10) step(1'b0, 4'hF, 1'b1);
        repeat (D) step(1'b0, 4'h3, 1'b1);

        // Request held high: back-to-back sequences
        repeat (2 * D + 3) step(1'b1, 4'hA, 1'b1);
        repeat (D + 5) step(1'b0, 4'hA, 1'b1);

        // Reset at pulse cycle 50 aborts the sequence
        a = cyc;
        step(1'b1, 4'hF, 1'b1);
        while (cyc < a + Q + 50) step(1'b0, 4'hF, 1'b1);
        step(1'b0, 4'hF, 1'b0);
        repeat (20) step(1'b0, 4'hF, 1'b1);

`ifdef ADRV9001_MSSI_EXT_SYNC_EN
        ext_sync        = 1'b1;
        trig_h[cyc + 3] = 1'b1;
        repeat (D + 10) step(1'b0, 4'h5, 1'b1);
        ext_sync = 1'b0;
        repeat (10) step(1'b0, 4'h5, 1'b1);
`endif

        rnd_ena = 4'h0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(19) == 0) rnd_ena = 4'($urandom);
            rnd_req  = ($urandom_range(149) == 0);
            rnd_rstn = ($urandom_range(2999) != 0);
            step(rnd_req, rnd_ena, rnd_rstn);
        end
        repeat (D + 10) step(1'b0, rnd_ena, 1'b1);

        chk("queue_drained", 32'(evq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
